hdmi_island_sched: RTL and testbench

Data-island scheduler for the HDMI transmit path. It arbitrates two packet requesters (InfoFrame source, audio source) for data-island slots in horizontal blanking. For each granted island it sequences preamble, leading guard band, 32-cycle packet body, trailing guard band and a mandatory control gap. It drives the encoder's aux/ade inputs and the CTL preamble bits, in step with the timing generator's hcount.

---
 rtl/hdmi_island_sched.sv | 91 +++++++++
 tb/tb_hdmi_island_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_island_sched.sv
// hdmi_island_sched: arbitrates two packet requesters into HDMI data-island slots and sequences PRE/LGB/DATA/TGB/GAP.
// Define SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module hdmi_island_sched #(
  parameter int HACTIVE   = 1920,
  parameter int HTOTAL    = 2200,
  parameter int START_OFS = 12,
  parameter int TAIL_RSV  = 12
) (
  input  logic        pix_clk,
  input  logic        sys_rst_n,
  input  logic [11:0] hcount,
  input  logic [1:0]  req,
  input  logic [11:0] pkt_word_0,
  input  logic [11:0] pkt_word_1,
  output logic [1:0]  grant,
  output logic        busy_id,
  output logic [4:0]  pkt_idx,
  output logic [1:0]  done,
  output logic        ade,
  output logic        dgb,
  output logic [3:0]  ctl,
  output logic [3:0]  aux0,
  output logic [3:0]  aux1,
  output logic [3:0]  aux2
);
  typedef enum logic [2:0] {IDLE, PRE, LGB, DATA, TGB, GAP} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, done_q;
  logic        busy_q, ade_q, dgb_q;
  logic [4:0]  pkt_idx_q;
  logic [3:0]  ctl_q;
  logic [11:0] aux_q;
  logic        win_ok, phase_end, start, winner;
  assign win_ok    = hcount >= 12'(HACTIVE + START_OFS) && hcount <= 12'(HTOTAL - TAIL_RSV - 56);
  assign phase_end = cnt_q == 6'd0;
  // The last GAP cycle doubles as the idle decision cycle so back-to-back islands are exactly 56 apart.
  assign start     = (state_q == IDLE || (state_q == GAP && phase_end)) && |req && win_ok;
`ifdef SCHED_FIXED_PRIO_EN
  assign winner = ~req[0];
`else
  logic last_q;
  assign winner = &req ? ~last_q : req[1];
  always_ff @(posedge pix_clk or negedge sys_rst_n)
    if (!sys_rst_n) last_q <= 1'b1;
    else if (start) last_q <= winner;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = state_q == IDLE ? 6'd0 : cnt_q - 6'd1;
    if (start) begin
      state_d = PRE;
      cnt_d   = 6'd7;
    end else if (state_q != IDLE && phase_end) begin
      state_d = state_q == PRE ? LGB : state_q == LGB ? DATA : state_q == DATA ? TGB : state_q == TGB ? GAP : IDLE;
      cnt_d   = state_q == LGB ? 6'd31 : state_q == TGB ? 6'd11 : (state_q == PRE || state_q == DATA) ? 6'd1 : 6'd0;
    end
  end
  always_ff @(posedge pix_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      busy_q    <= 1'b0;
      ade_q     <= 1'b0;
      dgb_q     <= 1'b0;
      pkt_idx_q <= 5'd0;
      ctl_q     <= 4'd0;
      aux_q     <= 12'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= start ? (winner ? 2'b10 : 2'b01) : 2'b00;
      busy_q    <= start ? winner : busy_q;
      done_q    <= (state_q == DATA && phase_end) ? (busy_q ? 2'b10 : 2'b01) : 2'b00;
      ade_q     <= state_d inside {LGB, DATA, TGB};
      dgb_q     <= state_d == LGB || state_d == TGB;
      ctl_q     <= state_d == PRE ? 4'b0101 : 4'd0;
      pkt_idx_q <= state_d == DATA ? ~cnt_d[4:0] : 5'd0;
      aux_q     <= state_q == DATA ? (busy_q ? pkt_word_1 : pkt_word_0) : 12'd0;
    end
  assign grant   = grant_q;
  assign done    = done_q;
  assign busy_id = busy_q;
  assign ade     = ade_q;
  assign dgb     = dgb_q;
  assign ctl     = ctl_q;
  assign pkt_idx = pkt_idx_q;
  assign {aux2, aux1, aux0} = aux_q;
endmodule

// File: tb/tb_hdmi_island_sched.sv
// tb_hdmi_island_sched: directed vectors and hand sequences for the data-island scheduler.
module tb_hdmi_island_sched;
`ifdef SCHED_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [11:0] hc = 12'd0;
  logic [1:0]  req = 2'b00;
  logic [11:0] pkt_word_0, pkt_word_1;
  logic [1:0]  grant, done;
  logic        busy_id, ade, dgb;
  logic [4:0]  pkt_idx;
  logic [3:0]  ctl, aux0, aux1, aux2;
  logic [27:0] outv;
  bit          run_hc = 1'b0;
  int          n_chk = 0, n_pass = 0;

  hdmi_island_sched dut (
    .pix_clk(clk), .sys_rst_n(sys_rst_n), .hcount(hc), .req(req),
    .pkt_word_0(pkt_word_0), .pkt_word_1(pkt_word_1),
    .grant(grant), .busy_id(busy_id), .pkt_idx(pkt_idx), .done(done),
    .ade(ade), .dgb(dgb), .ctl(ctl), .aux0(aux0), .aux1(aux1), .aux2(aux2)
  );

  always #5 clk = ~clk;
  assign pkt_word_0 = {pkt_idx, 7'h15};
  assign pkt_word_1 = {7'd0, pkt_idx};
  assign outv = {grant, busy_id, pkt_idx, done, ade, dgb, ctl, aux2, aux1, aux0};

  typedef struct {
    int         hc;
    logic [1:0] req;
    logic [1:0] exp_rr;
    logic [1:0] exp_fp;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (run_hc) hc = (hc == 12'd2199) ? 12'd0 : hc + 12'd1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int lim, input string nm);
    int n = 0;
    while (grant == 2'b00 && n < lim) begin
      step();
      n++;
    end
    chk({nm, " grant seen"}, {31'd0, grant != 2'b00}, 32'd1);
  endtask

  function automatic logic [11:0] word(input int id, input int k);
    return id != 0 ? {7'd0, 5'(k)} : {5'(k), 7'h15};
  endfunction

  // Expected outputs at offset o from the first PRE cycle of an island owned by id.
  function automatic logic [27:0] exp_out(input int id, input int o);
    logic [1:0]  oh;
    logic [11:0] w;
    oh = id != 0 ? 2'b10 : 2'b01;
    w  = (o >= 11 && o < 43) ? word(id, o - 11) : 12'd0;
    return {(o == 0) ? oh : 2'b00, 1'(id), (o >= 10 && o < 42) ? 5'(o - 10) : 5'd0,
            (o == 42) ? oh : 2'b00, 1'(o >= 8 && o < 44),
            1'(o == 8 || o == 9 || o == 42 || o == 43), (o < 8) ? 4'b0101 : 4'd0, w};
  endfunction

  task automatic island(input int id);
    for (int o = 0; o < 56; o++) begin
      chk($sformatf("island id%0d o%0d", id, o), {4'd0, outv}, {4'd0, exp_out(id, o)});
      step();
    end
  endtask

  initial begin
    logic [5:0] acc;
    int n;
    tv[0]  = '{1931, 2'b01, 2'b00, 2'b00};
    tv[1]  = '{1932, 2'b01, 2'b01, 2'b01};
    tv[2]  = '{2132, 2'b11, 2'b10, 2'b01};
    tv[3]  = '{2133, 2'b11, 2'b00, 2'b00};
    tv[4]  = '{100,  2'b11, 2'b00, 2'b00};
    tv[5]  = '{2000, 2'b11, 2'b01, 2'b01};
    tv[6]  = '{2000, 2'b10, 2'b10, 2'b10};
    tv[7]  = '{2000, 2'b10, 2'b10, 2'b10};
    tv[8]  = '{2000, 2'b00, 2'b00, 2'b00};
    tv[9]  = '{2000, 2'b11, 2'b01, 2'b01};
    tv[10] = '{0,    2'b01, 2'b00, 2'b00};
    tv[11] = '{2199, 2'b01, 2'b00, 2'b00};
    tv[12] = '{2000, 2'b11, 2'b10, 2'b01};
    #1;
    chk("reset outputs", {4'd0, outv}, 32'd0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      hc  = 12'(tv[i].hc);
      req = tv[i].req;
      step();
      chk($sformatf("vec%0d grant", i), {30'd0, grant}, {30'd0, FP ? tv[i].exp_fp : tv[i].exp_rr});
      req = 2'b00;
      hc  = 12'd0;
      repeat (60) step();
    end
    // Single requester, sweeping hcount: full island waveform then an immediate re-grant.
    do_reset();
    run_hc = 1'b1;
    hc  = 12'd1900;
    req = 2'b01;
    wait_grant(300, "single");
    chk("single start hcount", {20'd0, hc}, 32'd1933);
    island(0);
    chk("single regrant", {30'd0, grant}, 32'd1);
    req = 2'b00;
    repeat (60) step();
    // Both requesting from line start: alternation at 56-cycle spacing.
    do_reset();
    hc  = 12'd0;
    req = 2'b11;
    wait_grant(2300, "both");
    chk("both start hcount", {20'd0, hc}, 32'd1933);
    island(0);
    island(FP ? 0 : 1);
    island(0);
    req = 2'b00;
    repeat (60) step();
    // Window boundary with a running counter.
    run_hc = 1'b0;
    hc  = 12'd2132;
    run_hc = 1'b1;
    req = 2'b01;
    step();
    chk("edge 2132 grant", {30'd0, grant}, 32'd1);
    req = 2'b00;
    repeat (60) step();
    hc  = 12'd2133;
    req = 2'b01;
    step();
    chk("edge 2133 no grant", {30'd0, grant}, 32'd0);
    wait_grant(2300, "late");
    chk("late start hcount", {20'd0, hc}, 32'd1933);
    req = 2'b00;
    repeat (60) step();
    // Asynchronous reset in the middle of DATA.
    do_reset();
    hc  = 12'd1920;
    req = 2'b01;
    wait_grant(300, "pre-reset");
    n = 0;
    while (pkt_idx != 5'd10 && n < 60) begin
      step();
      n++;
    end
    chk("reached pkt_idx 10", {27'd0, pkt_idx}, 32'd10);
    #1 sys_rst_n = 1'b0;
    #1 chk("async reset outputs", {4'd0, outv}, 32'd0);
    req = 2'b11;
    step();
    step();
    chk("held reset outputs", {4'd0, outv}, 32'd0);
    sys_rst_n = 1'b1;
    wait_grant(2300, "post-reset");
    chk("post-reset grant", {30'd0, grant}, 32'd1);
    req = 2'b00;
    repeat (60) step();
    // No requests for three full lines.
    do_reset();
    for (int l = 0; l < 3; l++) begin
      acc = 6'd0;
      repeat (2200) begin
        step();
        acc = acc | {ade, |ctl, |grant, |done, dgb, |{aux2, aux1, aux0}};
      end
      chk($sformatf("idle line %0d", l), {26'd0, acc}, 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
